// File: rtl/mem_request_unit.sv
// mem_request_unit: MEM-stage data request controller (IDLE/REQ/DONE) with LL/SC link register.
// Define LLSC_EN to enable the link register, SC-fail resolution, datomic and sc_success.
module mem_request_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              mem_dREN,
   input  logic              mem_dWEN,
   input  logic              mem_atomic,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_adv,
   input  logic              mem_flush,
   input  logic              dhit,
   input  logic              ext_inv,
   input  logic [ADDR_W-1:0] ext_inv_addr,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic              datomic,
   output logic              dmem_busy,
   output logic              sc_success
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t r_state, w_next;
   logic w_live, w_busy, w_scfail, w_done_evt, w_unused;
`ifdef LLSC_EN
   logic              r_link_valid, r_sc_success;
   logic [ADDR_W-3:0] r_link_addr;
   logic [ADDR_W-3:0] w_mem_word, w_inv_word;
   logic              w_ll_hit, w_sc_hit, w_sc_done, w_own_clr, w_inv_hit;
   assign w_mem_word = mem_addr[ADDR_W-1:2];
   assign w_inv_word = ext_inv_addr[ADDR_W-1:2];
   assign w_scfail   = mem_dWEN & mem_atomic & ~(r_link_valid & (r_link_addr == w_mem_word));
   assign w_unused   = ^{mem_addr[1:0], ext_inv_addr[1:0]};
   assign datomic    = mem_atomic & w_busy;
   assign sc_success = r_sc_success;
`else
   assign w_scfail   = 1'b0;
   assign w_unused   = ^{mem_atomic, mem_addr, ext_inv, ext_inv_addr};
   assign datomic    = 1'b0;
   assign sc_success = 1'b0;
`endif
   // Requests are combinational so they appear the cycle the instruction enters MEM.
   always_comb begin
      w_live     = ~RST & ~mem_flush & (r_state != DONE);
      dmemREN    = w_live & mem_dREN & ~w_scfail;
      dmemWEN    = w_live & mem_dWEN & ~w_scfail;
      w_busy     = dmemREN | dmemWEN;
      dmem_busy  = w_busy;
      w_done_evt = (w_busy & dhit) | (w_live & w_scfail);
      w_next     = mem_flush ? IDLE :
                   ((r_state == DONE) | w_done_evt) ? (mem_adv ? IDLE : DONE) :
                   w_busy ? REQ : IDLE;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
`ifdef LLSC_EN
   assign w_ll_hit  = dmemREN & mem_atomic & dhit;
   assign w_sc_hit  = dmemWEN & mem_atomic & dhit;
   assign w_sc_done = w_sc_hit | (w_live & w_scfail);
   assign w_own_clr = dmemWEN & ~mem_atomic & dhit & (w_mem_word == r_link_addr);
   // A snoop of the address being linked this cycle beats the LL itself.
   assign w_inv_hit = ext_inv & (w_inv_word == (w_ll_hit ? w_mem_word : r_link_addr));
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         r_link_valid <= 1'b0;
         r_link_addr  <= '0;
         r_sc_success <= 1'b0;
      end else begin
         r_link_valid <= w_ll_hit ? ~w_inv_hit : r_link_valid & ~(w_sc_done | w_own_clr | w_inv_hit);
         if (w_ll_hit) r_link_addr <= w_mem_word;
         r_sc_success <= w_sc_hit | (r_sc_success & (r_state == DONE) & ~mem_adv & ~mem_flush);
      end
`endif
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: table-driven, scoreboarded bench for mem_request_unit.
// Expectations carry both LL/SC-enabled and plain (LL=LW, SC=SW) columns.
module tb_mem_request_unit;
`ifdef LLSC_EN
   localparam bit LLSC = 1'b1;
`else
   localparam bit LLSC = 1'b0;
`endif
   logic        CLK = 1'b0, RST = 1'b1;
   logic        mem_dREN = 0, mem_dWEN = 0, mem_atomic = 0, mem_adv = 0, mem_flush = 0, dhit = 0, ext_inv = 0;
   logic [31:0] mem_addr = 0, ext_inv_addr = 0;
   logic        dmemREN, dmemWEN, datomic, dmem_busy, sc_success;
   typedef struct {
      logic [3:0]  c;
      logic [31:0] a;
      logic [3:0]  d;
      logic [31:0] ia;
      logic [4:0]  el;
      logic [4:0]  ep;
   } vec_t;
   vec_t       v[$];
   logic [4:0] sb[$];
   int         n_cmp = 0, n_bad = 0;
   mem_request_unit #(.ADDR_W(32)) dut (
      .CLK(CLK), .RST(RST), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_atomic(mem_atomic),
      .mem_addr(mem_addr), .mem_adv(mem_adv), .mem_flush(mem_flush), .dhit(dhit), .ext_inv(ext_inv),
      .ext_inv_addr(ext_inv_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
      .dmem_busy(dmem_busy), .sc_success(sc_success)
   );
   always #5 CLK = ~CLK;
   function automatic logic [4:0] outs();
      return {dmemREN, dmemWEN, datomic, dmem_busy, sc_success};
   endfunction
   // c = {rst, ren, wen, atomic}; d = {adv, flush, dhit, inv}; outputs {REN, WEN, atomic, busy, sc_success}
   task automatic add(input logic [3:0] c, input logic [31:0] a, input logic [3:0] d,
                      input logic [31:0] ia, input logic [4:0] el, input logic [4:0] ep);
      vec_t t;
      t.c = c; t.a = a; t.d = d; t.ia = ia; t.el = el; t.ep = ep;
      v.push_back(t);
   endtask
   task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask
   initial begin
      add(4'b1000, 'h000, 4'b0000, 0, 5'b00000, 5'b00000);
      add(4'b0100, 'h040, 4'b0000, 0, 5'b10010, 5'b10010);
      add(4'b1100, 'h040, 4'b0000, 0, 5'b00000, 5'b00000);
      add(4'b0100, 'h040, 4'b1010, 0, 5'b10010, 5'b10010);
      add(4'b0100, 'h100, 4'b0000, 0, 5'b10010, 5'b10010);
      add(4'b0100, 'h100, 4'b0000, 0, 5'b10010, 5'b10010);
      add(4'b0100, 'h100, 4'b0000, 0, 5'b10010, 5'b10010);
      add(4'b0100, 'h100, 4'b1010, 0, 5'b10010, 5'b10010);
      add(4'b0000, 'h000, 4'b0000, 0, 5'b00000, 5'b00000);
      add(4'b0100, 'h104, 4'b0010, 0, 5'b10010, 5'b10010);
      add(4'b0100, 'h104, 4'b0000, 0, 5'b00000, 5'b00000);
      add(4'b0100, 'h104, 4'b1000, 0, 5'b00000, 5'b00000);
      add(4'b0100, 'h108, 4'b0000, 0, 5'b10010, 5'b10010);
      add(4'b0100, 'h108, 4'b1010, 0, 5'b10010, 5'b10010);
      add(4'b0101, 'h200, 4'b1010, 0, 5'b10110, 5'b10010);
      add(4'b0011, 'h200, 4'b0000, 0, 5'b01110, 5'b01010);
      add(4'b0011, 'h200, 4'b0010, 0, 5'b01110, 5'b01010);
      add(4'b0011, 'h200, 4'b0000, 0, 5'b00001, 5'b00000);
      add(4'b0011, 'h200, 4'b1000, 0, 5'b00001, 5'b00000);
      add(4'b0011, 'h200, 4'b0010, 0, 5'b00000, 5'b01010);
      add(4'b0011, 'h200, 4'b1000, 0, 5'b00000, 5'b00000);
      add(4'b0101, 'h200, 4'b1010, 0, 5'b10110, 5'b10010);
      add(4'b0000, 'h000, 4'b0001, 'h200, 5'b00000, 5'b00000);
      add(4'b0011, 'h200, 4'b0010, 0, 5'b00000, 5'b01010);
      add(4'b0011, 'h200, 4'b1000, 0, 5'b00000, 5'b00000);
      add(4'b0101, 'h200, 4'b1010, 0, 5'b10110, 5'b10010);
      add(4'b0000, 'h000, 4'b0001, 'h204, 5'b00000, 5'b00000);
      add(4'b0011, 'h200, 4'b0010, 0, 5'b01110, 5'b01010);
      add(4'b0011, 'h200, 4'b1000, 0, 5'b00001, 5'b00000);
      add(4'b0000, 'h000, 4'b0000, 0, 5'b00000, 5'b00000);
      add(4'b0101, 'h300, 4'b1010, 0, 5'b10110, 5'b10010);
      add(4'b0010, 'h300, 4'b0110, 0, 5'b00000, 5'b00000);
      add(4'b0011, 'h300, 4'b0010, 0, 5'b01110, 5'b01010);
      add(4'b0011, 'h300, 4'b1000, 0, 5'b00001, 5'b00000);
      add(4'b0101, 'h400, 4'b1011, 'h400, 5'b10110, 5'b10010);
      add(4'b0011, 'h400, 4'b0010, 0, 5'b00000, 5'b01010);
      add(4'b0011, 'h400, 4'b1000, 0, 5'b00000, 5'b00000);
      add(4'b0101, 'h500, 4'b1010, 0, 5'b10110, 5'b10010);
      add(4'b0010, 'h500, 4'b1010, 0, 5'b01010, 5'b01010);
      add(4'b0011, 'h500, 4'b0010, 0, 5'b00000, 5'b01010);
      add(4'b0000, 'h000, 4'b1000, 0, 5'b00000, 5'b00000);
      add(4'b0100, 'h600, 4'b0000, 0, 5'b10010, 5'b10010);
      add(4'b0100, 'h600, 4'b0100, 0, 5'b00000, 5'b00000);
      add(4'b0100, 'h604, 4'b1010, 0, 5'b10010, 5'b10010);
      add(4'b0101, 'h700, 4'b1010, 0, 5'b10110, 5'b10010);
      add(4'b1000, 'h000, 4'b0000, 0, 5'b00000, 5'b00000);
      add(4'b0011, 'h700, 4'b0010, 0, 5'b00000, 5'b01010);
      add(4'b0011, 'h700, 4'b1000, 0, 5'b00000, 5'b00000);
      for (int i = 0; i < v.size(); i++) begin
         @(negedge CLK);
         {RST, mem_dREN, mem_dWEN, mem_atomic} = v[i].c;
         {mem_adv, mem_flush, dhit, ext_inv} = v[i].d;
         mem_addr = v[i].a;
         ext_inv_addr = v[i].ia;
         sb.push_back(LLSC ? v[i].el : v[i].ep);
         #1;
         if (sb.size() == 0) chk($sformatf("vec%0d_empty", i), outs(), 5'bxxxxx);
         else chk($sformatf("vec%0d", i), outs(), sb.pop_front());
      end
      // Asynchronous reset in the middle of a clock high phase while a load is requesting.
      @(negedge CLK);
      {RST, mem_dREN, mem_dWEN, mem_atomic} = 4'b0100;
      {mem_adv, mem_flush, dhit, ext_inv} = 4'b0000;
      mem_addr = 'h800;
      @(posedge CLK);
      #2;
      chk("req_before_rst", outs(), 5'b10010);
      RST = 1'b1;
      #1;
      chk("async_rst_drop", outs(), 5'b00000);
      @(negedge CLK);
      RST = 1'b0;
      mem_dREN = 1'b0;
      #1;
      chk("idle_after_rst", outs(), 5'b00000);
      @(negedge CLK);
      mem_dREN = 1'b1;
      mem_addr = 'h804;
      #1;
      chk("new_req_after_rst", outs(), 5'b10010);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
